// File: rtl/tff_mod_counter_pkg.sv
// Legal-range limits shared by the T-FF modulo counter family.
package tff_mod_counter_pkg;

    localparam int unsigned     MIN_WIDTH   = 1;
    localparam int unsigned     MAX_WIDTH   = 32;
    localparam longint unsigned MIN_MODULUS = 2;

    // Largest modulus representable in a counter of the given width.
    function automatic longint unsigned max_modulus(input int unsigned width);
        return 64'(1) << width;
    endfunction

endpackage

// File: rtl/tff_sync_cell.sv
// Single T flip-flop cell with synchronous active-high reset to a per-bit value.
module tff_sync_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    input  logic rst_val,
    output logic q
);

    logic state_q;

    // Reset wins; otherwise invert on t and hold when t is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= rst_val;
        end else if (t) begin
            state_q <= ~state_q;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo up/down counter built from T-FF cells, with load, wrap pulse and cascade terminal count.
module tff_mod_counter
    import tff_mod_counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MODULUS   = 10,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'(1));
    localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RESET_VAL);

    // Parameter legality is enforced at elaboration time.
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("tff_mod_counter: WIDTH out of range");
    end
    if (MODULUS < MIN_MODULUS || MODULUS > max_modulus(WIDTH)) begin : g_bad_modulus
        $error("tff_mod_counter: MODULUS out of range");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("tff_mod_counter: RESET_VAL must be below MODULUS");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max;
    logic             at_zero;
    logic             load_ok;

    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);
    assign load_ok = (64'(load_val) < MODULUS);

    // Next count and wrap flag; reset is applied inside the cells and the wrap register.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_ok ? load_val : MAX_VAL;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // Each cell flips exactly where the next count differs from the current one.
    assign toggle = count_q ^ count_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_sync_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .t       (toggle[i]),
            .rst_val (RST_VEC[i]),
            .q       (count_q[i])
        );
    end

    // One-cycle wrap pulse, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign q    = count_q;
    assign wrap = wrap_q;
    assign tc   = en & ~load & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_tff_mod_counter.sv
// Self-checking bench: vector table for a decade counter, a two-digit cascade and a random run on a power-of-two counter.
module tb_tff_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Decade counter under table-driven test.
    logic       m_reset = 1'b1, m_en = 1'b0, m_up = 1'b1, m_load = 1'b0;
    logic [3:0] m_lv = '0;
    logic [3:0] m_q;
    logic       m_tc, m_wrap;

    tff_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_main (
        .clk(clk), .reset(m_reset), .en(m_en), .up(m_up), .load(m_load),
        .load_val(m_lv), .q(m_q), .tc(m_tc), .wrap(m_wrap)
    );

    // Two-digit cascade: high digit enabled by low digit's terminal count.
    logic       c_reset = 1'b1, c_en = 1'b0, c_up = 1'b1, c_load = 1'b0;
    logic [3:0] c_lv_lo = '0, c_lv_hi = '0;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

    tff_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_lo (
        .clk(clk), .reset(c_reset), .en(c_en), .up(c_up), .load(c_load),
        .load_val(c_lv_lo), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
    );
    tff_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_hi (
        .clk(clk), .reset(c_reset), .en(lo_tc), .up(c_up), .load(c_load),
        .load_val(c_lv_hi), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
    );

    // Full-range counter with a nonzero reset value.
    logic       p_reset = 1'b1, p_en = 1'b0, p_up = 1'b1, p_load = 1'b0;
    logic [2:0] p_lv = '0;
    logic [2:0] p_q;
    logic       p_tc, p_wrap;

    tff_mod_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(5)) u_pow2 (
        .clk(clk), .reset(p_reset), .en(p_en), .up(p_up), .load(p_load),
        .load_val(p_lv), .q(p_q), .tc(p_tc), .wrap(p_wrap)
    );

    typedef struct {
        logic       rst, en, up, ld;
        logic [3:0] lv;
        logic       tc;
        logic [3:0] q;
        logic       w;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] q;
        logic        w;
    } sb_t;

    vec_t vq[$];
    sb_t  sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic en, input logic up, input logic ld,
                       input logic [3:0] lv, input logic tc, input logic [3:0] q, input logic w);
        vec_t v;
        v = '{rst, en, up, ld, lv, tc, q, w};
        vq.push_back(v);
    endtask

    // Pop the oldest expectation and compare against a sampled q/wrap pair.
    task automatic sb_check(input logic [31:0] act_q, input logic act_w);
        sb_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            check({e.name, "_q"}, act_q, e.q);
            check({e.name, "_wrap"}, 32'(act_w), 32'(e.w));
        end
    endtask

    task automatic m_step(input vec_t v, input int idx);
        sb_t e;
        @(negedge clk);
        m_reset = v.rst; m_en = v.en; m_up = v.up; m_load = v.ld; m_lv = v.lv;
        #1;
        check($sformatf("vec%0d_tc", idx), 32'(m_tc), 32'(v.tc));
        e.name = $sformatf("vec%0d", idx);
        e.q    = 32'(v.q);
        e.w    = v.w;
        sb.push_back(e);
        @(posedge clk); #1;
        sb_check(32'(m_q), m_wrap);
    endtask

    task automatic c_edge(input string name, input logic [3:0] elo, input logic [3:0] ehi, input logic ehw);
        @(posedge clk); #1;
        check({name, "_lo"}, 32'(lo_q), 32'(elo));
        check({name, "_hi"}, 32'(hi_q), 32'(ehi));
        check({name, "_hiwrap"}, 32'(hi_wrap), 32'(ehw));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mq;
        logic mw;
        logic etc;
        sb_t e;

        // Up count 12 cycles from 0, then down, load/clamp, hold, direction flips and reset priority.
        for (int k = 0; k < 12; k++) begin
            add(0, 1, 1, 0, 4'd0, 1'((k % 10) == 9), 4'((k + 1) % 10), 1'((k % 10) == 9));
        end
        add(0, 0, 0, 1, 4'd2,  0, 4'd2, 0);
        add(0, 1, 0, 0, 4'd0,  0, 4'd1, 0);
        add(0, 1, 0, 0, 4'd0,  0, 4'd0, 0);
        add(0, 1, 0, 0, 4'd0,  1, 4'd9, 1);
        add(0, 1, 0, 0, 4'd0,  0, 4'd8, 0);
        add(0, 1, 1, 1, 4'd13, 0, 4'd9, 0);
        add(0, 1, 1, 1, 4'd3,  0, 4'd3, 0);
        add(0, 0, 0, 1, 4'd10, 0, 4'd9, 0);
        add(0, 1, 0, 1, 4'd0,  0, 4'd0, 0);
        add(0, 1, 0, 0, 4'd0,  1, 4'd9, 1);
        add(0, 1, 1, 1, 4'd4,  0, 4'd4, 0);
        add(0, 0, 1, 0, 4'd0,  0, 4'd4, 0);
        add(0, 0, 0, 0, 4'd0,  0, 4'd4, 0);
        add(0, 0, 1, 0, 4'd0,  0, 4'd4, 0);
        add(0, 1, 1, 0, 4'd0,  0, 4'd5, 0);
        add(0, 1, 0, 0, 4'd0,  0, 4'd4, 0);
        add(0, 1, 1, 0, 4'd0,  0, 4'd5, 0);
        add(0, 1, 0, 0, 4'd0,  0, 4'd4, 0);
        add(1, 1, 1, 1, 4'd5,  0, 4'd0, 0);
        add(1, 1, 0, 0, 4'd0,  1, 4'd0, 0);
        add(0, 0, 0, 0, 4'd0,  0, 4'd0, 0);

        // Reset with en=1 held over two edges.
        m_reset = 1'b1; m_en = 1'b1; m_up = 1'b1;
        @(posedge clk); #1;
        check("reset_edge_q", 32'(m_q), 32'(0));
        check("reset_edge_wrap", 32'(m_wrap), 32'(0));
        @(posedge clk); #1;
        check("reset_hold_q", 32'(m_q), 32'(0));

        foreach (vq[i]) m_step(vq[i], i);

        // Cascade: 08 -> 09 -> 10, then 98 -> 99 -> 00 -> 01.
        @(negedge clk);
        c_reset = 1'b0; c_load = 1'b1; c_lv_lo = 4'd8; c_lv_hi = 4'd0; c_en = 1'b0; c_up = 1'b1;
        c_edge("casc_ld08", 4'd8, 4'd0, 1'b0);
        @(negedge clk);
        c_load = 1'b0; c_en = 1'b1;
        #1 check("casc_lotc_at8", 32'(lo_tc), 32'(0));
        c_edge("casc_09", 4'd9, 4'd0, 1'b0);
        @(negedge clk); #1;
        check("casc_lotc_at9", 32'(lo_tc), 32'(1));
        c_edge("casc_10", 4'd0, 4'd1, 1'b0);
        @(negedge clk);
        c_load = 1'b1; c_lv_lo = 4'd8; c_lv_hi = 4'd9;
        c_edge("casc_ld98", 4'd8, 4'd9, 1'b0);
        @(negedge clk);
        c_load = 1'b0;
        c_edge("casc_99", 4'd9, 4'd9, 1'b0);
        @(negedge clk); #1;
        check("casc_hitc_at99", 32'(hi_tc), 32'(1));
        c_edge("casc_00", 4'd0, 4'd0, 1'b1);
        c_edge("casc_01", 4'd1, 4'd0, 1'b0);

        // Random run on the full-range counter against a behavioural model.
        @(negedge clk);
        p_reset = 1'b1;
        @(posedge clk); #1;
        check("pow2_reset_q", 32'(p_q), 32'(5));
        mq = 5;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            p_reset = ($urandom_range(0, 24) == 0);
            p_load  = ($urandom_range(0, 9) == 0);
            p_en    = ($urandom_range(0, 3) != 0);
            p_up    = ($urandom_range(0, 1) == 1);
            p_lv    = 3'($urandom_range(0, 7));
            #1;
            etc = p_en & ~p_load & ((p_up & (mq == 7)) | (~p_up & (mq == 0)));
            check($sformatf("pow2_%0d_tc", n), 32'(p_tc), 32'(etc));
            mw = 1'b0;
            if (p_reset) begin
                mq = 5;
            end else if (p_load) begin
                mq = int'(p_lv);
            end else if (p_en) begin
                if (p_up) begin
                    mw = (mq == 7);
                    mq = (mq + 1) % 8;
                end else begin
                    mw = (mq == 0);
                    mq = (mq + 7) % 8;
                end
            end
            e.name = $sformatf("pow2_%0d", n);
            e.q    = 32'(mq);
            e.w    = mw;
            sb.push_back(e);
            @(posedge clk); #1;
            sb_check(32'(p_q), p_wrap);
        end

        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
